// File: rtl/reg_file_pkg.sv
// Shared register-file constants used by decode, writeback and the register file.
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_REGS   = 32;

  // Address of the hardwired-zero register when that option is enabled.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: set by reserve, cleared by writeback, cleared by reset.
// Two combinational lookups, with optional same-cycle visibility of the clear.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  busy_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  busy_b
);

  localparam int FIRST = (ZERO_REG != 0) ? REG_ZERO + 1 : 0;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Loops start at FIRST so the zero register never turns busy, and only
  // in-range addresses can ever match.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    busy_d = busy_q;
    for (int i = FIRST; i < NUM_REGS; i++) begin
      // NOTE: combinational logic uses blocking '='; the later set overrides the clear.
      if (clr_en && clr_addr == ADDR_WIDTH'(i)) busy_d[i] = 1'b0;
      if (set_en && set_addr == ADDR_WIDTH'(i)) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update together.
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int i = FIRST; i < NUM_REGS; i++) begin
      if (addr_a == ADDR_WIDTH'(i))
        busy_a = (BYPASS != 0 && clr_en && clr_addr == addr_a) ? 1'b0 : busy_q[i];
      if (addr_b == ADDR_WIDTH'(i))
        busy_b = (BYPASS != 0 && clr_en && clr_addr == addr_b) ? 1'b0 : busy_q[i];
    end
  end

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with optional zero register, write bypass
// and a per-register busy scoreboard for operand stalls.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [ADDR_WIDTH-1:0]        RdAddrA,
  output logic signed [DATA_WIDTH-1:0] RdDataA,
  output logic                         BusyA,
  input  logic [ADDR_WIDTH-1:0]        RdAddrB,
  output logic signed [DATA_WIDTH-1:0] RdDataB,
  output logic                         BusyB,
  input  logic                         Write,
  input  logic [ADDR_WIDTH-1:0]        WrAddr,
  input  logic signed [DATA_WIDTH-1:0] WrData,
  input  logic                         Reserve,
  input  logic [ADDR_WIDTH-1:0]        ResAddr
);

  localparam int FIRST = (ZERO_REG != 0) ? REG_ZERO + 1 : 0;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    for (int i = FIRST; i < NUM_REGS; i++) begin
      if (Write && WrAddr == ADDR_WIDTH'(i)) regs_d[i] = WrData;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: every storage word is reset, because reset must make all reads return 0.
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Out-of-range and zero-register reads fall through to the 0 default.
  always_comb begin
    RdDataA = '0;
    RdDataB = '0;
    for (int i = FIRST; i < NUM_REGS; i++) begin
      if (RdAddrA == ADDR_WIDTH'(i))
        RdDataA = (BYPASS != 0 && Write && WrAddr == RdAddrA) ? WrData : regs_q[i];
      if (RdAddrB == ADDR_WIDTH'(i))
        RdDataB = (BYPASS != 0 && Write && WrAddr == RdAddrB) ? WrData : regs_q[i];
    end
  end

  rf_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .clk     (Clk),
    .reset   (Reset),
    .set_en  (Reserve),
    .set_addr(ResAddr),
    .clr_en  (Write),
    .clr_addr(WrAddr),
    .addr_a  (RdAddrA),
    .busy_a  (BusyA),
    .addr_b  (RdAddrB),
    .busy_b  (BusyB)
  );

endmodule
